// File: rtl/wb_ifetch.sv
// -----------------------------------------------------------------------------
// wb_ifetch -- Wishbone classic instruction fetch unit with a small
// first-word fall-through instruction buffer.
//
// Issues one word read at a time on a Wishbone classic bus. Each fetched word
// is pushed into a FIFO_DEPTH-entry buffer together with its address. Fetching
// pauses whenever the buffer would be full. A redirect flushes the buffer and
// restarts fetch at a new address. A redirect can arrive while a bus cycle is
// still open. In that case the open cycle is finished (DRAIN), its data is
// dropped, and then fetch restarts.
//
// Optional feature macro: IFETCH_ERR_EN
//   When defined, adds the wb_err_i port. An error termination pushes a
//   faulting entry and halts fetch until the next redirect. When undefined,
//   inst_fault_o is tied low and fetch never halts.
//
// Parameters
//   FIFO_DEPTH  instruction buffer entries (2..8)
//   RESET_PC    first fetch address after reset
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   redirect_i              flush buffer and restart fetch at redirect_pc_i
//   redirect_pc_i[31:0]     restart address (bits [1:0] ignored)
//   inst_valid_o            buffer head holds an instruction
//   inst_o[31:0]            head instruction word
//   inst_pc_o[31:0]         head instruction address
//   inst_fault_o            head entry came from a bus error
//   inst_ready_i            consumer pops the head when valid & ready
//   wb_cyc_o, wb_stb_o      Wishbone cycle/strobe (always equal)
//   wb_adr_o[29:0]          word address of the current fetch
//   wb_we_o, wb_sel_o[3:0]  constant read, all byte lanes
//   wb_dat_i[31:0]          read data, sampled on ack
//   wb_err_i                error termination (IFETCH_ERR_EN only)
//   wb_ack_i                normal termination
// -----------------------------------------------------------------------------
module wb_ifetch #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_fault_o,
  input  logic        inst_ready_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [29:0] wb_adr_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
`ifdef IFETCH_ERR_EN
  input  logic        wb_err_i,
`endif
  input  logic        wb_ack_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [29:0]      pc_q, pc_d;            // word address being / to be fetched
  logic [29:0]      drain_pc_q, drain_pc_d; // restart address held during DRAIN
  logic             halt_q, halt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             err_term;
  logic             bus_done;
  logic             push;
  logic             push_fault;
  logic             pop;
  logic [CNT_W-1:0] count_pp;
  logic [29:0]      redir_word;
  logic             unused_redirect_bits;

  logic [31:0] data_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

`ifdef IFETCH_ERR_EN
  logic        fault_mem [FIFO_DEPTH];
  assign err_term = wb_err_i;
`else
  assign err_term = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  // Byte-offset bits of the redirect address carry no meaning.
  assign unused_redirect_bits = ^redirect_pc_i[1:0];
  assign redir_word           = redirect_pc_i[31:2];

  assign bus_done = wb_ack_i | err_term;
  // A pop in the same cycle as a redirect is dropped: the flush wins.
  assign pop      = inst_valid_o & inst_ready_i & ~redirect_i;
  // Occupancy after a push in REQ; count_q < FIFO_DEPTH there, so no overflow.
  assign count_pp = count_q + CNT_W'(1) - CNT_W'(pop);

  // Fetch control: next state, fetch address, halt, and buffer push.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_pc_d = drain_pc_q;
    halt_d     = halt_q;
    push       = 1'b0;
    push_fault = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_i) begin
          pc_d    = redir_word;
          state_d = S_REQ;
        end else if (!halt_q && (count_q < DEPTH_C)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          if (bus_done) begin
            pc_d = redir_word;           // terminating data is dropped
          end else begin
            drain_pc_d = redir_word;     // keep adr stable until termination
            state_d    = S_DRAIN;
          end
        end else if (err_term) begin
          push       = 1'b1;
          push_fault = 1'b1;
          halt_d     = 1'b1;
          state_d    = S_IDLE;
        end else if (wb_ack_i) begin
          push = 1'b1;
          pc_d = pc_q + 30'd1;
          if (count_pp >= DEPTH_C) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (bus_done) begin
          state_d = S_REQ;
          pc_d    = redirect_i ? redir_word : drain_pc_q;
        end else if (redirect_i) begin
          drain_pc_d = redir_word;       // latest redirect wins
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_i) begin
      halt_d = 1'b0;
    end
  end

  // Buffer pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC[31:2];
      drain_pc_q <= RESET_PC[31:2];
      halt_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drain_pc_q <= drain_pc_d;
      halt_q     <= halt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage; contents are qualified by count_q so need no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= push_fault ? 32'h0 : wb_dat_i;
      pc_mem[wr_ptr_q]   <= {pc_q, 2'b00};
`ifdef IFETCH_ERR_EN
      fault_mem[wr_ptr_q] <= push_fault;
`endif
    end
  end

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = data_mem[rd_ptr_q];
  assign inst_pc_o    = pc_mem[rd_ptr_q];
`ifdef IFETCH_ERR_EN
  assign inst_fault_o = inst_valid_o & fault_mem[rd_ptr_q];
`else
  assign inst_fault_o = 1'b0;
`endif

  assign wb_cyc_o = (state_q != S_IDLE);
  assign wb_stb_o = wb_cyc_o;
  assign wb_adr_o = pc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;

endmodule

// File: tb/tb_wb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_wb_ifetch -- directed self-checking bench for wb_ifetch.
// A behavioural ROM slave acknowledges every read after a programmable number
// of wait cycles (lat = 0 gives the one-cycle delayed ack). Its data for word
// address a is (a + 1) * 0x11. A negedge monitor records every popped buffer
// entry and tracks that adr/stb stay stable until termination.
// Build with +define+IFETCH_ERR_EN to include the bus-error scenario.
// -----------------------------------------------------------------------------
module tb_wb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;

  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        cyc, stb, we;
  logic [29:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat = 32'h0;
  logic        ack = 1'b0;
`ifdef IFETCH_ERR_EN
  logic        err = 1'b0;
  logic        err_en = 1'b0;
  logic [29:0] err_adr = 30'h0;
`endif

  int lat = 0;
  int wcnt = 0;
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int viol = 0;
  int cycle = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } ent_t;
  ent_t q[$];

  logic        pend = 1'b0;
  logic [29:0] pend_adr = 30'h0;

  always #5 clk = ~clk;

  wb_ifetch dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_fault_o  (inst_fault),
    .inst_ready_i  (ready),
    .wb_cyc_o      (cyc),
    .wb_stb_o      (stb),
    .wb_adr_o      (adr),
    .wb_we_o       (we),
    .wb_sel_o      (sel),
    .wb_dat_i      (dat),
`ifdef IFETCH_ERR_EN
    .wb_err_i      (err),
`endif
    .wb_ack_i      (ack)
  );

  function automatic logic [31:0] rom(input logic [29:0] a);
    return ({2'b00, a} + 32'd1) * 32'h11;
  endfunction

  // ROM slave with lat wait cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      wcnt <= 0;
`ifdef IFETCH_ERR_EN
      err  <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef IFETCH_ERR_EN
      err <= 1'b0;
      if (cyc && stb && !ack && !err) begin
`else
      if (cyc && stb && !ack) begin
`endif
        if (wcnt >= lat) begin
          wcnt <= 0;
`ifdef IFETCH_ERR_EN
          if (err_en && adr == err_adr) err <= 1'b1;
          else begin
            ack <= 1'b1;
            dat <= rom(adr);
          end
`else
          ack <= 1'b1;
          dat <= rom(adr);
`endif
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: popped entries, ack count, request stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (inst_valid && ready && !redirect)
        q.push_back('{inst_pc, inst, inst_fault, cycle});
      if (ack) ack_cnt++;
      if (pend && (!stb || adr != pend_adr)) viol++;
`ifdef IFETCH_ERR_EN
      pend = stb && !ack && !err;
`else
      pend = stb && !ack;
`endif
      pend_adr = adr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input int l);
    rst_n    = 1'b0;
    redirect = 1'b0;
    ready    = rdy;
    lat      = l;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_entries(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (q.size() >= n) break;
      tick();
    end
    if (q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", cyc); end
    checks++; if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", stb); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++; if (inst_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", inst_fault); end
    checks++; if (adr !== 30'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", adr); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we); end
    checks++; if (sel !== 4'hF) begin errors++; $display("FAIL reset_sel: got %h want f", sel); end
  endtask

  task automatic test_main();
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int base;
    bit ok;
    do_reset(1'b1, 0);
    base = q.size();
    tick();
    checks++; if (stb !== 1'b1 || adr !== 30'h0) begin errors++; $display("FAIL main_first_stb: got stb=%b adr=%h want stb=1 adr=0", stb, adr); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL main_valid_early: got %b want 0", inst_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h11 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL main_first_inst: got v=%b d=%h pc=%h want v=1 d=11 pc=0", inst_valid, inst, inst_pc); end
    wait_entries(base + 4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL main_timeout: got %0d entries want 4", q.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (q[base+i].pc !== 32'(i * 4) || q[base+i].data !== exp_d[i] || q[base+i].fault !== 1'b0) begin
          errors++; $display("FAIL main_entry%0d: got pc=%h d=%h f=%b want pc=%h d=%h f=0", i, q[base+i].pc, q[base+i].data, q[base+i].fault, i * 4, exp_d[i]); end
      end
      checks++; if (q[base+2].cyc - q[base+1].cyc != 2) begin
        errors++; $display("FAIL main_throughput: got %0d cycles per word want 2", q[base+2].cyc - q[base+1].cyc); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int base, a0;
    bit ok;
    do_reset(1'b0, 0);
    a0 = ack_cnt;
    base = q.size();
    repeat (20) tick();
    checks++; if (ack_cnt - a0 != 2) begin errors++; $display("FAIL bp_ack_count: got %0d want 2", ack_cnt - a0); end
    checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL bp_cyc_low: got %b want 0", cyc); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
    ready = 1'b1;
    wait_entries(base + 4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d entries want 4", q.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (q[base+i].pc !== 32'(i * 4) || q[base+i].data !== exp_d[i]) begin
          errors++; $display("FAIL bp_entry%0d: got pc=%h d=%h want pc=%h d=%h", i, q[base+i].pc, q[base+i].data, i * 4, exp_d[i]); end
      end
    end
  endtask

  task automatic test_redirect_drain();
    int base;
    bit ok, seen;
    do_reset(1'b1, 2);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (stb && adr == 30'h1) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drain_no_stb4: got no request at 0x4 want one"); end
    else begin
      tick();
      base = q.size();
      redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      checks++; if (stb !== 1'b1 || adr !== 30'h1) begin errors++; $display("FAIL drain_hold1: got stb=%b adr=%h want stb=1 adr=1", stb, adr); end
      redirect_pc = 32'h100;
      tick();
      checks++; if (stb !== 1'b1 || adr !== 30'h1) begin errors++; $display("FAIL drain_hold2: got stb=%b adr=%h want stb=1 adr=1", stb, adr); end
      redirect = 1'b0;
      wait_entries(base + 2, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL drain_timeout: got %0d entries want 2", q.size() - base); end
      else begin
        checks++; if (q[base].pc !== 32'h100 || q[base].data !== 32'h451) begin
          errors++; $display("FAIL drain_first: got pc=%h d=%h want pc=100 d=451", q[base].pc, q[base].data); end
        checks++; if (q[base+1].pc !== 32'h104 || q[base+1].data !== 32'h462) begin
          errors++; $display("FAIL drain_second: got pc=%h d=%h want pc=104 d=462", q[base+1].pc, q[base+1].data); end
      end
    end
  endtask

  task automatic test_redirect_ack();
    int base;
    bit ok, seen;
    do_reset(1'b0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ack && inst_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rack_no_window: got no ack with valid head want one"); end
    else begin
      base = q.size();
      redirect = 1'b1; redirect_pc = 32'h40; ready = 1'b1;
      tick();
      redirect = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rack_flush: got valid=%b want 0", inst_valid); end
      checks++; if (stb !== 1'b1 || adr !== 30'h10) begin errors++; $display("FAIL rack_adr: got stb=%b adr=%h want stb=1 adr=10", stb, adr); end
      wait_entries(base + 1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rack_timeout: got %0d entries want 1", q.size() - base); end
      else begin
        checks++; if (q[base].pc !== 32'h40 || q[base].data !== 32'h121) begin
          errors++; $display("FAIL rack_entry: got pc=%h d=%h want pc=40 d=121", q[base].pc, q[base].data); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    logic [31:0] exp_d  [3] = '{32'h3FFF_FFEF, 32'h4000_0000, 32'h11};
    int base;
    bit ok;
    do_reset(1'b1, 0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    base = q.size();
    tick();
    redirect = 1'b0;
    checks++; if (stb !== 1'b1 || adr !== 30'h3FFF_FFFE) begin errors++; $display("FAIL wrap_adr: got stb=%b adr=%h want stb=1 adr=3ffffffe", stb, adr); end
    wait_entries(base + 3, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: got %0d entries want 3", q.size() - base); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (q[base+i].pc !== exp_pc[i] || q[base+i].data !== exp_d[i]) begin
          errors++; $display("FAIL wrap_entry%0d: got pc=%h d=%h want pc=%h d=%h", i, q[base+i].pc, q[base+i].data, exp_pc[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 0);
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL areset_bus: got cyc=%b stb=%b want 0 0", cyc, stb); end
    checks++; if (adr !== 30'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL areset_state: got adr=%h v=%b want adr=0 v=0", adr, inst_valid); end
  endtask

`ifdef IFETCH_ERR_EN
  task automatic test_err();
    int base;
    bit ok;
    err_en = 1'b1; err_adr = 30'h2;
    do_reset(1'b1, 0);
    base = q.size();
    wait_entries(base + 3, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL err_timeout: got %0d entries want 3", q.size() - base); end
    else begin
      checks++; if (q[base+1].pc !== 32'h4 || q[base+1].fault !== 1'b0) begin
        errors++; $display("FAIL err_before: got pc=%h f=%b want pc=4 f=0", q[base+1].pc, q[base+1].fault); end
      checks++; if (q[base+2].pc !== 32'h8 || q[base+2].fault !== 1'b1 || q[base+2].data !== 32'h0) begin
        errors++; $display("FAIL err_entry: got pc=%h f=%b d=%h want pc=8 f=1 d=0", q[base+2].pc, q[base+2].fault, q[base+2].data); end
      repeat (10) tick();
      checks++; if (cyc !== 1'b0 || q.size() != base + 3) begin
        errors++; $display("FAIL err_halt: got cyc=%b entries=%0d want cyc=0 entries=3", cyc, q.size() - base); end
      err_en = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      wait_entries(base + 4, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL err_restart_timeout: got %0d entries want 4", q.size() - base); end
      else begin
        checks++; if (q[base+3].pc !== 32'h0 || q[base+3].fault !== 1'b0 || q[base+3].data !== 32'h11) begin
          errors++; $display("FAIL err_restart: got pc=%h f=%b d=%h want pc=0 f=0 d=11", q[base+3].pc, q[base+3].fault, q[base+3].data); end
      end
    end
  endtask
`endif

  task automatic test_stability();
    checks++; if (viol != 0) begin errors++; $display("FAIL bus_stability: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_main();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
`ifdef IFETCH_ERR_EN
    test_err();
`endif
    test_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ifetch.md
WB_IFETCH -- requirements
Module: wb_ifetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of fetched-instruction buffer entries (legal 2..8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 redirect_i  in  1  flush buffer and restart fetch at redirect_pc_i.
REQ-006 redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-007 inst_valid_o  out  1  buffer head holds an instruction.
REQ-008 inst_o  out  32  head instruction word.
REQ-009 inst_pc_o  out  32  address of head instruction.
REQ-010 inst_fault_o  out  1  head entry came from a bus error.
REQ-011 inst_ready_i  in  1  consumer pops head when inst_valid_o & inst_ready_i.
REQ-012 wb_cyc_o, wb_stb_o  out  1 each  Wishbone classic read cycle; always driven equal.
REQ-013 wb_adr_o  out  30  word address [31:2] of current fetch.
REQ-014 wb_we_o  out  1  constant 0; wb_sel_o  out  4  constant 4'hF.
REQ-015 wb_dat_i  in  32  read data, sampled only when wb_ack_i high.
REQ-016 wb_ack_i  in  1  cycle termination.
REQ-017 wb_err_i  in  1  error termination; present only with IFETCH_ERR_EN.

Function
REQ-018 States: IDLE (no bus cycle), REQ (cyc/stb high, awaiting ack), DRAIN (cycle held for a stale fetch whose data is discarded).
REQ-019 At most one outstanding bus cycle; wb_adr_o and wb_stb_o stable from assertion until the terminating ack.
REQ-020 IDLE->REQ when occupancy < FIFO_DEPTH and not halted; first request in the first cycle after reset release.
REQ-021 REQ + ack: push {wb_dat_i, fetch pc, fault=0}; fetch pc += 4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-022 REQ + ack: stay in REQ with next address presented next cycle if post-push occupancy (including same-cycle pop) < FIFO_DEPTH, else go IDLE.
REQ-023 Buffer is first-word fall-through: inst_o/inst_pc_o/inst_fault_o valid in the cycle inst_valid_o rises; push and pop in the same cycle permitted.
REQ-024 Buffer never overflows; push to a full buffer is impossible by construction of REQ-022.
REQ-025 redirect_i: buffer emptied (inst_valid_o low next cycle), fetch pc := {redirect_pc_i[31:2],2'b00}, halt cleared.
REQ-026 redirect_i in IDLE: REQ with new address next cycle.
REQ-027 redirect_i in REQ without ack same cycle: go DRAIN, keep cyc/stb/adr; ack in DRAIN discards data, next cycle REQ at redirected pc.
REQ-028 redirect_i coincident with ack (REQ or DRAIN): data discarded, REQ at redirect pc next cycle.
REQ-029 Later redirect in DRAIN overwrites the pending pc; latest redirect wins.
REQ-030 Pop coincident with redirect: pop ignored, buffer empty.
REQ-031 Against the 1-cycle delayed-ack ROM slave, sustained throughput is one word per 2 cycles.

Reset
REQ-032 While rst_ni low: state IDLE, fetch pc = RESET_PC, buffer empty, halt 0, wb_cyc_o = wb_stb_o = 0, inst_valid_o = 0, inst_fault_o = 0, wb_adr_o = RESET_PC[31:2].
REQ-033 Reset asserted mid-cycle drops cyc/stb immediately; any late ack after release is ignored unless a request is active.

Configuration
REQ-034 Macro IFETCH_ERR_EN defined: wb_err_i exists; err in REQ pushes {32'h0, fetch pc, fault=1}, sets halt, goes IDLE; no further fetch until redirect_i; err in DRAIN is discarded like ack.
REQ-035 IFETCH_ERR_EN undefined: wb_err_i absent, inst_fault_o tied 0, halt never set.

Verification
REQ-036 Reset release, ROM words 0..3 = 0x11,0x22,0x33,0x44, inst_ready_i=1 -> stb first cycle, inst_valid_o first high cycle 2, pcs 0,4,8,C in order.
REQ-037 inst_ready_i=0 with FIFO_DEPTH=2 -> exactly 2 acks then cyc low; raise ready -> fetch resumes at pc 8, no loss/duplication.
REQ-038 redirect_i to 0x100 one cycle after stb at 0x4 -> stb held until ack, word 0x4 never appears, next delivered pc 0x100.
REQ-039 redirect_i to 0x40 coincident with ack and pop -> buffer empty next cycle, next request adr 0x40>>2.
REQ-040 RESET_PC=0xFFFF_FFF8 -> delivered pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-041 IFETCH_ERR_EN, err on pc 0x8 -> entry pc 8 with fault=1, no further cycles; redirect to 0x0 -> fetch restarts, fault 0.
